// File: rtl/rr_bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   - arb_state_t : arbiter FSM states (ARB_IDLE / ARB_OWN)
//   - ARB_N_REQ_DEF / ARB_TENURE_DEF : default requester count and tenure,
//     shared with the requester generators
//   - clog2() : ceiling log2, used to size index and counter fields
package rr_bus_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_OWN  = 1'b1
   } arb_state_t;

   localparam int ARB_N_REQ_DEF  = 4;
   localparam int ARB_TENURE_DEF = 8;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   req      requester -> arbiter  request pulses, one bit per requester
//   rel      requester -> arbiter  early release (only the owner's bit matters)
//   gnt      arbiter -> requester  one-hot grant
//   gnt_id   arbiter -> requester  index of the current / last owner
//   busy     arbiter -> requester  any grant active
//   drop_cnt arbiter -> requester  merged-request count (ARB_DROP_CNT_EN only)
// Modports: master = requester side, slave = arbiter side.
// Optional feature macro: ARB_DROP_CNT_EN adds drop_cnt and the DROP_W parameter.
interface rr_bus_arbiter_if
   import rr_bus_arbiter_pkg::*;
#(
   parameter int N_REQ  = ARB_N_REQ_DEF,
   parameter int ID_W   = clog2(ARB_N_REQ_DEF)
`ifdef ARB_DROP_CNT_EN
   ,
   parameter int DROP_W = 8
`endif
) ();

   logic [N_REQ-1:0]  req;
   logic [N_REQ-1:0]  rel;
   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_id;
   logic              busy;
`ifdef ARB_DROP_CNT_EN
   logic [DROP_W-1:0] drop_cnt;

   modport master (output req, rel, input gnt, gnt_id, busy, drop_cnt);
   modport slave  (input req, rel, output gnt, gnt_id, busy, drop_cnt);
`else
   modport master (output req, rel, input gnt, gnt_id, busy);
   modport slave  (input req, rel, output gnt, gnt_id, busy);
`endif

endinterface

// File: rtl/rr_bus_arbiter_pick.sv
// rr_pick: combinational rotate-priority picker.
//   cand  in   N_REQ  candidate requesters
//   ptr   in   ID_W   last owner; the scan starts at ptr+1
//   any   out  1      at least one candidate present
//   win   out  ID_W   first candidate found scanning ptr+1, ptr+2, ... mod N_REQ
module rr_pick
   import rr_bus_arbiter_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ_DEF,
   parameter int ID_W  = clog2(ARB_N_REQ_DEF)
) (
   input  logic [N_REQ-1:0] cand,
   input  logic [ID_W-1:0]  ptr,
   output logic             any,
   output logic [ID_W-1:0]  win
);

   // Scan from the farthest position back towards ptr+1 so the nearest
   // candidate after ptr is the last one written and therefore wins.
   always_comb begin
      int idx;
      any = 1'b0;
      win = '0;
      idx = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (cand[idx[ID_W-1:0]]) begin
            any = 1'b1;
            win = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: latches request pulses as pending and grants the shared bus
// one-hot, round-robin, for at most TENURE cycles, with a one-cycle
// turnaround after every tenure.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   rr_bus_arbiter_if.slave (req, rel in; gnt, gnt_id, busy, drop_cnt out)
// Optional feature macro: ARB_DROP_CNT_EN builds the saturating merged-request
// counter drop_cnt; without it the port and the counter are absent.
module rr_bus_arbiter
   import rr_bus_arbiter_pkg::*;
#(
   parameter int N_REQ  = ARB_N_REQ_DEF,
   parameter int TENURE = ARB_TENURE_DEF,
   parameter int ID_W   = 2,
   parameter int DROP_W = 8
) (
   input logic             clk,
   input logic             rst,
   rr_bus_arbiter_if.slave bus
);

   // Counter only has to hold TENURE-1; keep at least one bit for TENURE=1.
   localparam int CNT_W = (TENURE > 1) ? clog2(TENURE) : 1;

   // Catch parameter sets that would silently mis-size the index fields.
   if (ID_W != clog2(N_REQ)) begin : g_bad_id_w
      $error("rr_bus_arbiter: ID_W must equal clog2(N_REQ)");
   end
   if (DROP_W < 1) begin : g_bad_drop_w
      $error("rr_bus_arbiter: DROP_W must be at least 1");
   end

   arb_state_t       state, state_nxt;
   logic [N_REQ-1:0] pending, pending_nxt;
   logic [N_REQ-1:0] gnt_r, gnt_nxt;
   logic [ID_W-1:0]  gnt_id_r, gnt_id_nxt;
   logic [ID_W-1:0]  ptr, ptr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [N_REQ-1:0] cand;
   logic [N_REQ-1:0] win_onehot;
   logic [ID_W-1:0]  win;
   logic             any;

   // A request arriving in IDLE competes on the same edge as older pending ones.
   assign cand       = pending | bus.req;
   assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .cand (cand),
      .ptr  (ptr),
      .any  (any),
      .win  (win)
   );

   // State register: grant, owner index, rotation pointer, tenure counter
   // and pending requests. Reset drops the grant at once and forgets pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARB_IDLE;
         pending  <= '0;
         gnt_r    <= '0;
         gnt_id_r <= '0;
         ptr      <= ID_W'(N_REQ - 1);
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         pending  <= pending_nxt;
         gnt_r    <= gnt_nxt;
         gnt_id_r <= gnt_id_nxt;
         ptr      <= ptr_nxt;
         cnt      <= cnt_nxt;
      end
   end

   // Next-state logic. In IDLE the winner is granted and its pending bit
   // cleared on the same edge. In OWN, requests from the owner are merged
   // away, and the tenure ends on the counter reaching zero or an owner
   // release; both together still give one release. Leaving OWN always
   // passes through IDLE, which provides the turnaround cycle.
   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      gnt_nxt     = gnt_r;
      gnt_id_nxt  = gnt_id_r;
      ptr_nxt     = ptr;
      cnt_nxt     = cnt;
      case (state)
         ARB_IDLE: begin
            if (any) begin
               pending_nxt = cand & ~win_onehot;
               gnt_nxt     = win_onehot;
               gnt_id_nxt  = win;
               cnt_nxt     = CNT_W'(TENURE - 1);
               state_nxt   = ARB_OWN;
            end else begin
               pending_nxt = cand;
            end
         end
         ARB_OWN: begin
            pending_nxt = pending | (bus.req & ~gnt_r);
            if ((cnt == '0) || bus.rel[gnt_id_r]) begin
               gnt_nxt   = '0;
               ptr_nxt   = gnt_id_r;
               state_nxt = ARB_IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   assign bus.gnt    = gnt_r;
   assign bus.gnt_id = gnt_id_r;
   assign bus.busy   = |gnt_r;

`ifdef ARB_DROP_CNT_EN
   logic [DROP_W-1:0] drop_cnt;
   logic              drop_hit;

   // A request is merged when its requester is already pending or already
   // owns the bus; any number of merges in one cycle counts once.
   assign drop_hit = |(bus.req & (pending | gnt_r));

   // Saturating merge counter, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop_hit && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + DROP_W'(1);
      end
   end

   assign bus.drop_cnt = drop_cnt;
`endif

endmodule
